// File: rtl/armv8_enc_pkg.sv
// rtl/armv8_enc_pkg.sv - LEGv8 encoder opcode map, field layout and FSM states
package armv8_enc_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_ORR  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_ADDI = 4'd4,
        OP_SUBI = 4'd5,
        OP_MOVZ = 4'd6,
        OP_B    = 4'd7,
        OP_CBZ  = 4'd8,
        OP_LDUR = 4'd9,
        OP_STUR = 4'd10
    } enc_op_t;

    localparam logic [31:0] BASE_AND  = 32'h8A00_0000;
    localparam logic [31:0] BASE_ORR  = 32'hAA00_0000;
    localparam logic [31:0] BASE_ADD  = 32'h8B00_0000;
    localparam logic [31:0] BASE_SUB  = 32'hCB00_0000;
    localparam logic [31:0] BASE_ADDI = 32'h9100_0000;
    localparam logic [31:0] BASE_SUBI = 32'hD100_0000;
    localparam logic [31:0] BASE_MOVZ = 32'hD280_0000;
    localparam logic [31:0] BASE_B    = 32'h1400_0000;
    localparam logic [31:0] BASE_CBZ  = 32'hB400_0000;
    localparam logic [31:0] BASE_LDUR = 32'hF840_0000;
    localparam logic [31:0] BASE_STUR = 32'hF800_0000;

    localparam int RN_SH    = 5;
    localparam int RM_SH    = 16;
    localparam int ALUI_SH  = 10;
    localparam int MOVW_SH  = 5;
    localparam int HW_SH    = 21;
    localparam int CBR_SH   = 5;
    localparam int DT_SH    = 12;

    localparam int ALUI_W   = 12;
    localparam int MOVW_W   = 16;
    localparam int BR_W     = 26;
    localparam int CBR_W    = 19;
    localparam int DT_W     = 9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } fsm_t;

endpackage

// File: rtl/insn_field_pack.sv
// rtl/insn_field_pack.sv - op/fields to 32-bit word; INSN_ENCODER_RANGECHK_EN adds immediate range check
module insn_field_pack
    import armv8_enc_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [25:0] imm,
    input  logic [1:0]  hw,
    output logic [31:0] word,
    output logic        legal
);

    logic imm_ok;

`ifdef INSN_ENCODER_RANGECHK_EN
    // Immediate must fit its field: zero-extended for ALU/MOVZ, sign-extended for CBZ/D-format
    always_comb begin
        imm_ok = 1'b1;
        case (op)
            OP_ADDI, OP_SUBI: imm_ok = (imm[25:12] == '0);
            OP_MOVZ:          imm_ok = (imm[25:16] == '0);
            OP_LDUR, OP_STUR: imm_ok = (imm[25:8] == {18{imm[8]}});
            OP_CBZ:           imm_ok = (imm[25:18] == {8{imm[18]}});
            default:          imm_ok = 1'b1;
        endcase
    end
`else
    assign imm_ok = 1'b1;
`endif

    // Base opcode ORed with the fields each format uses; wide immediates are truncated
    always_comb begin
        word  = '0;
        legal = imm_ok;
        case (op)
            OP_AND:  word = BASE_AND | (32'(rm) << RM_SH) | (32'(rn) << RN_SH) | 32'(rd);
            OP_ORR:  word = BASE_ORR | (32'(rm) << RM_SH) | (32'(rn) << RN_SH) | 32'(rd);
            OP_ADD:  word = BASE_ADD | (32'(rm) << RM_SH) | (32'(rn) << RN_SH) | 32'(rd);
            OP_SUB:  word = BASE_SUB | (32'(rm) << RM_SH) | (32'(rn) << RN_SH) | 32'(rd);
            OP_ADDI: word = BASE_ADDI | (32'(imm[ALUI_W-1:0]) << ALUI_SH) | (32'(rn) << RN_SH) | 32'(rd);
            OP_SUBI: word = BASE_SUBI | (32'(imm[ALUI_W-1:0]) << ALUI_SH) | (32'(rn) << RN_SH) | 32'(rd);
            OP_MOVZ: word = BASE_MOVZ | (32'(hw) << HW_SH) | (32'(imm[MOVW_W-1:0]) << MOVW_SH) | 32'(rd);
            OP_B:    word = BASE_B | 32'(imm[BR_W-1:0]);
            OP_CBZ:  word = BASE_CBZ | (32'(imm[CBR_W-1:0]) << CBR_SH) | 32'(rd);
            OP_LDUR: word = BASE_LDUR | (32'(imm[DT_W-1:0]) << DT_SH) | (32'(rn) << RN_SH) | 32'(rd);
            OP_STUR: word = BASE_STUR | (32'(imm[DT_W-1:0]) << DT_SH) | (32'(rn) << RN_SH) | 32'(rd);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/insn_encoder.sv
// rtl/insn_encoder.sv - streaming LEGv8 encoder top; INSN_ENCODER_RANGECHK_EN enables immediate range check
module insn_encoder
    import armv8_enc_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [25:0]       in_imm,
    input  logic [1:0]        in_hw,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_insn,
    output logic              done,
    output logic [1:0]        err
);

    fsm_t              state;
    logic [ADDR_W-1:0] cnt;
    logic [31:0]       word;
    logic              legal;
    logic              accept;

    insn_field_pack u_pack (
        .op    (in_op),
        .rd    (in_rd),
        .rn    (in_rn),
        .rm    (in_rm),
        .imm   (in_imm),
        .hw    (in_hw),
        .word  (word),
        .legal (legal)
    );

    assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign done     = (state == S_DONE);

    // Program sequencing, address counter, sticky errors and the single output register
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state     <= S_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_insn  <= '0;
            err       <= 2'b00;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_RUN;
                        cnt   <= '0;
                        err   <= 2'b00;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (legal) begin
                            out_valid <= 1'b1;
                            out_addr  <= cnt;
                            out_insn  <= word;
                            cnt       <= cnt + 1'b1;
                            if (cnt == {ADDR_W{1'b1}}) begin
                                err[1] <= 1'b1;
                            end
                        end else begin
                            err[0] <= 1'b1;
                        end
                        if (in_last) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!out_valid || out_ready) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
